// File: rtl/opc_multi_profile_if.sv
`default_nettype none
// ============================================================================
// Module      : opc_multi_profile_if
// Description : SPI configuration bus, profile select and phase-output
//               bundle of the multi-profile DDS phase generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface opc_multi_profile_if #(
  parameter int N = 14,
  parameter int P = 4
);
  logic                 sclk;
  logic                 mosi;
  logic                 ss;
  logic                 miso;
  logic [$clog2(P)-1:0] profile_sel;
  logic [N-1:0]         phase;
  logic                 wrap;
  logic                 busy;
  logic                 cmd_err;

  // Host / SPI master side
  modport master (
    output sclk, mosi, ss, profile_sel,
    input  miso, phase, wrap, busy, cmd_err
  );

  // Configurator side
  modport slave (
    input  sclk, mosi, ss, profile_sel,
    output miso, phase, wrap, busy, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/opc_multi_profile.sv
`default_nettype none
// ============================================================================
// Module      : opc_multi_profile
// Description : Multi-profile DDS operation configurator. An oversampled
//               SPI slave loads P FTW/POW profiles; a phase accumulator
//               driven by the selected profile produces the phase word.
// Revision    : 1.0 - initial release
// ============================================================================
module opc_multi_profile #(
  parameter int M = 48,
  parameter int N = 14,
  parameter int B = 8,
  parameter int P = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  opc_multi_profile_if.slave bus
);

  localparam int IW = $clog2(P);
  localparam int CW = $clog2(M);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_INSTR   = 3'd1;
  localparam logic [2:0] c_ST_WDATA   = 3'd2;
  localparam logic [2:0] c_ST_SYNC    = 3'd3;
  localparam logic [2:0] c_ST_RSYNC   = 3'd4;
  localparam logic [2:0] c_ST_RDATA   = 3'd5;
  localparam logic [2:0] c_ST_DISCARD = 3'd6;

  localparam logic [1:0] c_TGT_FTW = 2'b00;
  localparam logic [1:0] c_TGT_POW = 2'b01;
  localparam logic [1:0] c_TGT_CLR = 2'b10;
  localparam logic [1:0] c_TGT_RSV = 2'b11;

  localparam logic [5:0]    c_NPROF  = 6'(P);
  localparam logic [CW-1:0] c_LAST_B = CW'(B - 1);
  localparam logic [CW-1:0] c_LAST_M = CW'(M - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers: [0] metastable stage, [1] synchronised, [2] previous value
  // ---------------------------------------------------------------------------
  logic [2:0]    sclk_q;
  logic [2:0]    ss_q;
  logic [1:0]    mosi_q;
  logic [IW-1:0] sel_meta_q;
  logic [IW-1:0] sel_q;

  // Bring the asynchronous SPI pins and profile select into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q     <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      sel_meta_q <= '0;
      sel_q      <= '0;
    end else begin
      sclk_q     <= {sclk_q[1:0], bus.sclk};
      ss_q       <= {ss_q[1:0], bus.ss};
      mosi_q     <= {mosi_q[0], bus.mosi};
      sel_meta_q <= bus.profile_sel;
      sel_q      <= sel_meta_q;
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  assign w_sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign w_sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign w_ss_rise   =  ss_q[1]   & ~ss_q[2];
  assign w_ss_fall   = ~ss_q[1]   &  ss_q[2];

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  sr_q, sr_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cmd_err_q, cmd_err_d;
  logic          w_commit;
  logic          w_load_rd;

  // The same shift register collects the instruction byte and the data word;
  // the instruction is decoded from the freshly shifted low byte.
  logic [M-1:0] w_sr_shift;
  logic [7:0]   w_instr;
  logic         w_instr_bad;
  assign w_sr_shift  = {sr_q[M-2:0], mosi_q[1]};
  assign w_instr     = w_sr_shift[7:0];
  assign w_instr_bad = (w_instr[6:5] == c_TGT_RSV) ||
                       (w_instr[7] && (w_instr[6:5] == c_TGT_CLR)) ||
                       ({1'b0, w_instr[4:0]} >= c_NPROF);

  // Next-state logic: slave select rise aborts, otherwise advance on sclk rise
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tgt_d     = tgt_q;
    idx_d     = idx_q;
    cmd_err_d = 1'b0;
    w_commit  = 1'b0;
    w_load_rd = 1'b0;
    if (w_ss_rise) begin
      cnt_d = '0;
      case (state_q)
        c_ST_IDLE:    state_d = c_ST_IDLE;
        c_ST_DISCARD: state_d = c_ST_IDLE;
        c_ST_INSTR: begin
          cmd_err_d = (cnt_q != '0);
          state_d   = c_ST_IDLE;
        end
        default: begin
          cmd_err_d = 1'b1;
          state_d   = c_ST_IDLE;
        end
      endcase
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_ss_fall) begin
            state_d = c_ST_INSTR;
            cnt_d   = '0;
          end
        end
        c_ST_INSTR: begin
          if (w_sclk_rise) begin
            sr_d  = w_sr_shift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == c_LAST_B) begin
              cnt_d = '0;
              tgt_d = w_instr[6:5];
              idx_d = w_instr[IW-1:0];
              if (w_instr_bad) begin
                cmd_err_d = 1'b1;
                state_d   = c_ST_DISCARD;
              end else if (w_instr[7]) begin
                state_d = c_ST_RSYNC;
              end else if (w_instr[6:5] == c_TGT_CLR) begin
                state_d = c_ST_SYNC;
              end else begin
                state_d = c_ST_WDATA;
              end
            end
          end
        end
        c_ST_WDATA: begin
          if (w_sclk_rise) begin
            sr_d  = w_sr_shift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == c_LAST_M) begin
              cnt_d   = '0;
              state_d = c_ST_SYNC;
            end
          end
        end
        c_ST_SYNC: begin
          if (w_sclk_rise) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == c_LAST_B) begin
              cnt_d    = '0;
              w_commit = 1'b1;
              state_d  = c_ST_INSTR;
            end
          end
        end
        c_ST_RSYNC: begin
          if (w_sclk_rise) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == c_LAST_B) begin
              cnt_d     = '0;
              w_load_rd = 1'b1;
              state_d   = c_ST_RDATA;
            end
          end
        end
        c_ST_RDATA: begin
          if (w_sclk_rise) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == c_LAST_M) begin
              cnt_d   = '0;
              state_d = c_ST_INSTR;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM and command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= c_ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      tgt_q     <= '0;
      idx_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      tgt_q     <= tgt_d;
      idx_q     <= idx_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Profile register file
  // ---------------------------------------------------------------------------
  logic [M-1:0] ftw_q [P];
  logic [M-1:0] pow_q [P];

  // Atomic single-clk commit of the shadow word into the addressed profile
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < P; i++) begin
        ftw_q[i] <= '0;
        pow_q[i] <= '0;
      end
    end else if (w_commit && (tgt_q == c_TGT_FTW)) begin
      ftw_q[idx_q] <= sr_q;
    end else if (w_commit && (tgt_q == c_TGT_POW)) begin
      pow_q[idx_q] <= sr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator
  // ---------------------------------------------------------------------------
  logic [M:0]     w_sum;
  logic [N-1:0]   w_phase_top;
  logic [M-N-1:0] w_unused_phase_low;
  logic [M-1:0]   acc_q;
  logic [N-1:0]   phase_q;
  logic           wrap_q;

  assign w_sum = {1'b0, acc_q} + {1'b0, ftw_q[sel_q]};
  assign {w_phase_top, w_unused_phase_low} = acc_q + pow_q[sel_q];

  // Accumulate every clk; ACC_CLEAR overrides that clk's addition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      wrap_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      phase_q <= w_phase_top;
      if (w_commit && (tgt_q == c_TGT_CLR)) begin
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        acc_q  <= w_sum[M-1:0];
        wrap_q <= w_sum[M];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-back path
  // ---------------------------------------------------------------------------
  logic [M-1:0] rd_sr_q;
  logic         miso_q;

  // Load on leaving RSYNC, shift out on each sclk fall; miso is 0 elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sr_q <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (state_q != c_ST_RDATA) begin
        miso_q <= 1'b0;
      end else if (w_sclk_fall) begin
        miso_q <= rd_sr_q[M-1];
      end
      if (w_load_rd) begin
        rd_sr_q <= (tgt_q == c_TGT_FTW) ? ftw_q[idx_q] : pow_q[idx_q];
      end else if ((state_q == c_ST_RDATA) && w_sclk_fall) begin
        rd_sr_q <= {rd_sr_q[M-2:0], 1'b0};
      end
    end
  end

  assign bus.miso    = miso_q;
  assign bus.phase   = phase_q;
  assign bus.wrap    = wrap_q;
  assign bus.busy    = (state_q != c_ST_IDLE);
  assign bus.cmd_err = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_opc_multi_profile.sv
`default_nettype none
// ============================================================================
// Module      : tb_opc_multi_profile
// Description : Self-checking bench for opc_multi_profile: directed SPI
//               transactions against a cycle-level arithmetic DDS model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_opc_multi_profile;
  localparam int M  = 48;
  localparam int N  = 14;
  localparam int B  = 8;
  localparam int P  = 4;
  localparam int H  = 8;   // sclk half period in clk cycles
  localparam int IW = $clog2(P);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  opc_multi_profile_if #(.N(N), .P(P)) bus ();
  opc_multi_profile #(.M(M), .N(N), .B(B), .P(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: profile arrays plus modular accumulator. Asynchronous inputs take
  // effect two clk after they are driven (two-stage synchroniser); a commit
  // lands on the third clk after the final sync-byte sclk rise.
  // --------------------------------------------------------------------------
  logic [M-1:0]  m_ftw [P];
  logic [M-1:0]  m_pow [P];
  logic [M-1:0]  m_acc, m_pa;
  logic [M:0]    m_sum;
  logic [N-1:0]  m_phase;
  logic          m_wrap;
  logic [IW-1:0] m_sel, sel_d1;
  int            pend_cnt = 0;
  int            pend_tgt = 0;
  int            pend_idx = 0;
  logic [M-1:0]  pend_val = '0;
  bit            chk_en = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < P; i++) begin
        m_ftw[i] = '0;
        m_pow[i] = '0;
      end
      m_acc = '0; m_phase = '0; m_wrap = 1'b0;
      m_sel = '0; sel_d1 = '0; pend_cnt = 0;
    end else begin
      m_pa    = m_acc + m_pow[m_sel];
      m_phase = m_pa[M-1:M-N];
      m_sum   = {1'b0, m_acc} + {1'b0, m_ftw[m_sel]};
      m_acc   = m_sum[M-1:0];
      m_wrap  = m_sum[M];
      m_sel   = sel_d1;
      sel_d1  = bus.profile_sel;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          case (pend_tgt)
            0: m_ftw[pend_idx] = pend_val;
            1: m_pow[pend_idx] = pend_val;
            default: begin m_acc = '0; m_wrap = 1'b0; end
          endcase
        end
      end
    end
  end

  // Compare process: phase and wrap every cycle outside reset
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("phase", 64'(bus.phase), 64'(m_phase));
      check("wrap", 64'(bus.wrap), 64'(m_wrap));
    end
  end

  int err_pulses = 0;
  int busy_drop = 0;
  bit in_read = 0;
  always @(negedge clk) begin
    if (!reset && bus.cmd_err) err_pulses++;
    if (in_read && !bus.busy) busy_drop++;
  end

  // --------------------------------------------------------------------------
  // SPI master (mode 0): drive mosi with the falling edge, sample miso just
  // before the rising edge.
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [63:0] v, input int n, input bit arm_last,
                          output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = v[i];
      tick(H);
      rx = {rx[62:0], bus.miso};
      bus.sclk = 1'b1;
      if (arm_last && i == 0) pend_cnt = 3;
      tick(H);
    end
  endtask

  task automatic ss_low();
    bus.ss = 1'b0;
    tick(H);
  endtask

  task automatic ss_high();
    bus.sclk = 1'b0;
    tick(H);
    bus.ss = 1'b1;
    tick(2 * H);
  endtask

  task automatic spi_write(input int tgt, input int idx, input logic [M-1:0] val);
    logic [63:0] rx;
    pend_tgt = tgt; pend_idx = idx; pend_val = val;
    ss_low();
    spi_xfer(64'((tgt << 5) | idx), 8, 1'b0, rx);
    if (tgt != 2) spi_xfer(64'(val), M, 1'b0, rx);
    spi_xfer(64'h5A, B, 1'b1, rx);
    ss_high();
  endtask

  task automatic spi_read(input logic [7:0] instr, output logic [M-1:0] data,
                          output logic [B-1:0] sync_rx);
    logic [63:0] rx;
    ss_low();
    in_read = 1;
    spi_xfer(64'(instr), 8, 1'b0, rx);
    spi_xfer(64'hA5, B, 1'b0, rx);
    sync_rx = rx[B-1:0];
    spi_xfer(64'h0, M, 1'b0, rx);
    data = rx[M-1:0];
    in_read = 0;
    ss_high();
  endtask

  task automatic bad_instr(input logic [7:0] instr, input string name);
    logic [63:0] rx;
    int e0;
    e0 = err_pulses;
    ss_low();
    spi_xfer(64'(instr), 8, 1'b0, rx);
    spi_xfer(64'hFF, 8, 1'b0, rx);
    ss_high();
    check(name, 64'(err_pulses - e0), 64'd1);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [63:0]  rx;
    logic [N-1:0] p0, pa, d;
    logic [M-1:0] rd;
    logic [B-1:0] srx;
    int           t, e0;

    bus.sclk = 1'b0; bus.mosi = 1'b0; bus.ss = 1'b1; bus.profile_sel = '0;
    tick(3);
    check("rst_phase", 64'(bus.phase), 64'd0);
    check("rst_wrap", 64'(bus.wrap), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'(bus.cmd_err), 64'd0);
    check("rst_miso", 64'(bus.miso), 64'd0);
    reset = 1'b0;
    chk_en = 1;
    tick(4);

    // Reset in the middle of a data word
    ss_low();
    spi_xfer(64'h00, 8, 1'b0, rx);
    spi_xfer(64'hFFF, 12, 1'b0, rx);
    check("wdata_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick(2);
    check("midrst_phase", 64'(bus.phase), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_miso", 64'(bus.miso), 64'd0);
    bus.ss = 1'b1; bus.sclk = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(4);

    // FTW profile 0 = one phase LSB per clk
    spi_write(0, 0, 48'h000400000000);
    tick(4);
    p0 = bus.phase;
    tick(10);
    d = bus.phase - p0;
    check("phase_step10", 64'(d), 64'd10);
    t = 0;
    while (!bus.wrap && t < 20000) begin tick(1); t++; end
    check("wrap_seen", 64'(t < 20000), 64'd1);
    check("wrap_phase", 64'(bus.phase), 64'h3FFF);
    tick(1);
    t = 1;
    while (!bus.wrap && t < 20000) begin tick(1); t++; end
    check("wrap_period", 64'(t), 64'd16384);

    // Profile 1: half-cycle offset, zero frequency; switch 0 -> 1
    spi_write(1, 1, 48'h800000000000);
    spi_write(0, 1, 48'h0);
    p0 = bus.phase;
    bus.profile_sel = 2'd1;
    tick(6);
    pa = bus.phase;
    tick(5);
    check("frozen", 64'(bus.phase), 64'(pa));
    d = pa - 14'h2000 - p0;
    check("switch_cont", 64'(d), 64'd3);

    // Write then read back FTW profile 2
    spi_write(0, 2, 48'h123456789ABC);
    busy_drop = 0;
    spi_read(8'h82, rd, srx);
    check("read_ftw2", 64'(rd), 64'h123456789ABC);
    check("rsync_miso", 64'(srx), 64'd0);
    check("busy_read", 64'(busy_drop), 64'd0);

    // Invalid instructions
    bad_instr(8'h60, "err_reserved");
    bad_instr(8'h05, "err_index");
    bad_instr(8'hC0, "err_rdclear");
    spi_read(8'hA1, rd, srx);
    check("read_pow1", 64'(rd), 64'h800000000000);
    spi_read(8'h82, rd, srx);
    check("ftw2_kept", 64'(rd), 64'h123456789ABC);

    // Abort during the sync byte: no commit, error pulse
    e0 = err_pulses;
    ss_low();
    spi_xfer(64'h01, 8, 1'b0, rx);
    spi_xfer(64'h000400000000, M, 1'b0, rx);
    spi_xfer(64'h0, 4, 1'b0, rx);
    ss_high();
    check("abort_err", 64'(err_pulses - e0), 64'd1);
    pa = bus.phase;
    tick(5);
    check("abort_nocommit", 64'(bus.phase), 64'(pa));

    // Accumulator clear: phase becomes POW[1] top bits
    spi_write(2, 0, '0);
    tick(2);
    check("clear_phase", 64'(bus.phase), 64'h2000);

    // Back to profile 0 and run on
    bus.profile_sel = 2'd0;
    tick(50);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opc_multi_profile.md
Name: opc_multi_profile

Overview:
Multi-profile operation profile configurator for the DDS core. An SPI slave, sampled in the system clock domain, loads P independent profiles. Each profile holds an M-bit frequency tuning word (FTW) and an M-bit phase offset word (POW). An M-bit phase accumulator, driven by the profile selected on profile_sel, produces an N-bit phase word for the phase-to-amplitude stage.

Parameters:
M, 48, accumulator / FTW / POW width in bits; must be a multiple of B
N, 14, phase output width (N <= M)
B, 8, SPI byte width
P, 4, number of profiles; power of 2, 2..32

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock, mode 0, asynchronous to clk
mosi  in  1  SPI data in, MSB first
ss  in  1  SPI slave select, active-low
miso  out  1  SPI data out, MSB first
profile_sel  in  log2(P)  active profile index, asynchronous
phase  out  N  phase word
wrap  out  1  one-clk pulse on accumulator carry-out
busy  out  1  high while a transaction is in progress
cmd_err  out  1  one-clk pulse on invalid instruction or aborted transaction

Behaviour:
- Reset (async, active-high): all FTW/POW registers, accumulator, phase, miso, wrap, busy, cmd_err = 0. FSM -> IDLE. Synchronisers are cleared.
- sclk, mosi, ss and profile_sel each pass through 2-FF synchronisers. Requirement: f_clk >= 4*f_sclk.
- mosi is sampled on the detected sclk rising edge. miso updates on the detected sclk falling edge.
- Instruction byte (MSB first):
  - bit7: R/W (1 = read)
  - bits6:5: target (00 FTW, 01 POW, 10 ACC_CLEAR, 11 reserved)
  - bits4:0: profile index; bits above log2(P) must be 0
- Invalid instruction: reserved target, read of ACC_CLEAR, or index >= P. Response: cmd_err pulse, FSM -> DISCARD until ss rises.
- FSM states:
  - IDLE: ss falling -> INSTR, busy=1.
  - INSTR: shift B bits.
    - Write FTW/POW -> WDATA.
    - ACC_CLEAR -> SYNC.
    - Read -> RSYNC.
  - WDATA: shift M bits into the shadow register -> SYNC.
  - SYNC: count B sclk cycles, mosi ignored. At the end, commit: shadow -> target[index], or clear the accumulator. Then -> INSTR for the next command without ss toggling.
  - RSYNC: B sclk cycles, miso = 0. At the end, load the target register into the output shift register -> RDATA.
  - RDATA: shift M bits out MSB first, first bit valid after the first falling edge -> INSTR.
  - DISCARD: ignore sclk.
- ss rising in any state other than IDLE/INSTR-at-bit-0: abort to IDLE, no commit, busy=0. cmd_err pulses if a command was partially received.
- Commit is atomic in one clk. A write to the active profile affects the accumulator from the next clk.
- Accumulator, every clk: acc <= acc + FTW[sel], modulo 2^M. wrap = carry-out, registered together with acc.
- ACC_CLEAR commit: acc <= 0, overriding that clk's addition.
- phase <= (acc + POW[sel]) bits [M-1:M-N], registered: phase lags acc by one clk.
- Profile switch: sel follows the synchronised profile_sel. The accumulator is not reset (phase-continuous switch); the new FTW and POW apply from the cycle sel changes.
- Commit and profile switch in the same clk: commit applies, and the new sel indexes the updated register file.
- miso is driven 0 outside RSYNC/RDATA (no tri-state).

Test Plan:
- Reset mid-WDATA (after 20 bits) -> all outputs 0, FSM IDLE; the next valid write completes normally.
- Write FTW profile 0 = 0x000400000000 (instr 0x00, 6 data bytes, sync byte), profile_sel=0 -> phase increments by 1 per clk; wrap pulses every 2^14 clk.
- Write POW profile 1 = 0x800000000000, FTW profile 1 = 0, switch profile_sel 0->1 -> phase = 0x2000 + frozen acc[47:34], with no accumulator discontinuity.
- Read FTW profile 2 after writing 0x123456789ABC (instr 0x82, 8 garbage sync clocks, 48 bits) -> miso stream equals 0x123456789ABC MSB first; busy high throughout.
- Instr 0x60 (reserved) and 0x05 with P=4 -> cmd_err one-clk pulse each; no register changes; busy drops on ss rise.
- Write FTW with ss raised during the sync byte -> no commit, old FTW retained, cmd_err pulse. Then ACC_CLEAR (instr 0x40 + sync) -> acc=0, phase = POW[sel][47:34] two clk later.
